// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: decode modes, fetch FSM states and
// compare-flag bit positions.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_REG    = 2'b00,
    MODE_TARGET = 2'b01,
    MODE_IMM    = 2'b10,
    MODE_NOP    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_DONE = 2'd2
  } fstate_e;

  localparam int CMP_ZERO = 2;
  localparam int CMP_EQ   = 1;
  localparam int CMP_GT   = 0;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: holds PC, decode mode, previous instruction and compare
// flags, committing decoder requests each edge while the program runs.
//   state  | meaning
//   F_IDLE | after reset, waiting for Start
//   F_RUN  | program executing, decoder requests committed each edge
//   F_DONE | program finished (Ack or overrun), outputs frozen until Start
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W     = 9,
  parameter int PROG_LEN = 512,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic [8:0]       BranchTarget,
  input  logic [1:0]       NextState,
  input  logic [8:0]       PrevInstructionIn,
  input  logic             CMPLoadEn,
  input  logic [2:0]       CMPBitsIn,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [1:0]       CurrState,
  output logic [8:0]       PrevInstruction,
  output logic [2:0]       CMPBits,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] FIRST_PC = PC_W'(START_PC);

  fstate_e         state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  mode_e           mode_q, mode_d;
  logic [8:0]      prev_q, prev_d;
  logic [2:0]      cmp_q, cmp_d;
  logic            fault_q, fault_d;
  logic            cnt_clr, cnt_en;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= F_IDLE;
      pc_q    <= FIRST_PC;
      mode_q  <= MODE_REG;
      prev_q  <= '0;
      cmp_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
      cmp_q   <= cmp_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    prev_d  = prev_q;
    cmp_d   = cmp_q;
    fault_d = fault_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      F_RUN: begin
        cnt_en = 1'b1;
        if (CMPLoadEn) cmp_d = CMPBitsIn;
        if (Ack) begin
          state_d = F_DONE;
        end else begin
          prev_d = PrevInstructionIn;
          if (BranchEn) begin
            pc_d   = BranchTarget[PC_W-1:0];
            mode_d = MODE_REG;
          end else if (pc_q == LAST_PC) begin
            state_d = F_DONE;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
            // An illegal mode falls back to regular decode and is flagged.
            if (NextState == MODE_NOP) begin
              mode_d  = MODE_REG;
              fault_d = 1'b1;
            end else begin
              mode_d = mode_e'(NextState);
            end
          end
        end
      end
      default: begin
        if (Start) begin
          state_d = F_RUN;
          pc_d    = FIRST_PC;
          mode_d  = MODE_REG;
          prev_d  = '0;
          cmp_d   = '0;
          fault_d = 1'b0;
          cnt_clr = 1'b1;
        end
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (CycleCount)
  );

  assign ProgCtr         = pc_q;
  assign CurrState       = mode_q;
  assign PrevInstruction = prev_q;
  assign CMPBits         = {cmp_q[CMP_ZERO], cmp_q[CMP_EQ], cmp_q[CMP_GT]};
  assign Running         = (state_q == F_RUN);
  assign Done            = (state_q == F_DONE);
  assign Fault           = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked
// against a rule-level model of a full-size and a small (PROG_LEN=16) instance.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, BranchEn, CMPLoadEn, Ack;
  logic [8:0] BranchTarget, PrevInstructionIn;
  logic [1:0] NextState;
  logic [2:0] CMPBitsIn;

  logic [8:0]  pc_a, prev_a, pc_b, prev_b;
  logic [1:0]  cs_a, cs_b;
  logic [2:0]  cmp_a, cmp_b;
  logic        run_a, done_a, flt_a, run_b, done_b, flt_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fetch_sequencer dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn),
    .BranchTarget(BranchTarget), .NextState(NextState),
    .PrevInstructionIn(PrevInstructionIn), .CMPLoadEn(CMPLoadEn),
    .CMPBitsIn(CMPBitsIn), .Ack(Ack), .ProgCtr(pc_a), .CurrState(cs_a),
    .PrevInstruction(prev_a), .CMPBits(cmp_a), .Running(run_a),
    .Done(done_a), .Fault(flt_a), .CycleCount(cnt_a));

  fetch_sequencer #(.PROG_LEN(16), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn),
    .BranchTarget(BranchTarget), .NextState(NextState),
    .PrevInstructionIn(PrevInstructionIn), .CMPLoadEn(CMPLoadEn),
    .CMPBitsIn(CMPBitsIn), .Ack(Ack), .ProgCtr(pc_b), .CurrState(cs_b),
    .PrevInstruction(prev_b), .CMPBits(cmp_b), .Running(run_b),
    .Done(done_b), .Fault(flt_b), .CycleCount(cnt_b));

  // Model: index 0 = full-size instance, 1 = PROG_LEN 16 / 4-bit counter.
  // Phase: 0 idle, 1 running, 2 done.
  int m_ph[2], m_pc[2], m_mode[2], m_prev[2], m_cmp[2], m_flt[2], m_cnt[2];
  int prog_len[2] = '{512, 16};
  int cnt_max[2]  = '{65535, 15};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_pc[k] = 0; m_mode[k] = 0; m_prev[k] = 0;
      m_cmp[k] = 0; m_flt[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_ph[k] != 1) begin
        if (Start) begin
          m_ph[k] = 1; m_pc[k] = 0; m_mode[k] = 0; m_prev[k] = 0;
          m_cmp[k] = 0; m_flt[k] = 0; m_cnt[k] = 0;
        end
      end else begin
        if (CMPLoadEn) m_cmp[k] = int'(CMPBitsIn);
        if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
        if (Ack) begin
          m_ph[k] = 2;
        end else begin
          m_prev[k] = int'(PrevInstructionIn);
          if (BranchEn) begin
            m_pc[k] = int'(BranchTarget);
            m_mode[k] = 0;
          end else if (m_pc[k] == prog_len[k] - 1) begin
            m_ph[k] = 2;
            m_flt[k] = 1;
          end else begin
            m_pc[k] = (m_pc[k] + 1) % 512;
            if (NextState == 2'b11) begin
              m_mode[k] = 0;
              m_flt[k] = 1;
            end else begin
              m_mode[k] = int'(NextState);
            end
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    Start = 0; BranchEn = 0; BranchTarget = 0; NextState = 0;
    PrevInstructionIn = 0; CMPLoadEn = 0; CMPBitsIn = 0; Ack = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    model_reset();
    #2;
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 0;
    idle_inputs();
    @(posedge Clk); #1;
    do_reset();
    checks++;
    if ({pc_a, cs_a, prev_a, cmp_a, run_a, done_a, flt_a, cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_state got pc=%0d cs=%0d prev=%0d cmp=%0d run=%0d done=%0d flt=%0d cnt=%0d exp all zero",
               pc_a, cs_a, prev_a, cmp_a, run_a, done_a, flt_a, cnt_a);
    end
    // Abort mid-run at PC 37 with a non-regular decode mode pending.
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 36; i++) tick();
    NextState = 2'b01; tick(); NextState = 0;
    checks++;
    if (pc_a !== 9'd37 || cs_a !== 2'b01 || run_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort got pc=%0d cs=%0d run=%0d exp pc=37 cs=1 run=1", pc_a, cs_a, run_a);
    end
    Reset = 1;
    model_reset();
    #1;
    checks++;
    if (pc_a !== 9'd0 || cs_a !== 2'b00 || run_a !== 1'b0 || flt_a !== 1'b0) begin
      errors++;
      $display("FAIL async_abort got pc=%0d cs=%0d run=%0d flt=%0d exp 0 0 0 0", pc_a, cs_a, run_a, flt_a);
    end
    #1;
    Reset = 0;
  endtask

  task automatic test_run_and_ack();
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pc_a !== 9'd5 || cnt_a !== 16'd5 || run_a !== 1'b1) begin
      errors++;
      $display("FAIL run5 got pc=%0d cnt=%0d run=%0d exp pc=5 cnt=5 run=1", pc_a, cnt_a, run_a);
    end
    Ack = 1; tick(); Ack = 0;
    checks++;
    if (done_a !== 1'b1 || run_a !== 1'b0 || pc_a !== 9'd5 || cnt_a !== 16'd6) begin
      errors++;
      $display("FAIL ack_done got done=%0d run=%0d pc=%0d cnt=%0d exp done=1 run=0 pc=5 cnt=6",
               done_a, run_a, pc_a, cnt_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || pc_a !== 9'd5 || cnt_a !== 16'd6) begin
      errors++;
      $display("FAIL done_hold got done=%0d pc=%0d cnt=%0d exp done=1 pc=5 cnt=6", done_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_branch();
    Start = 1; tick(); Start = 0;
    checks++;
    if (run_a !== 1'b1 || done_a !== 1'b0 || pc_a !== 9'd0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL restart got run=%0d done=%0d pc=%0d cnt=%0d exp run=1 done=0 pc=0 cnt=0",
               run_a, done_a, pc_a, cnt_a);
    end
    for (int i = 0; i < 10; i++) tick();
    NextState = 2'b01; PrevInstructionIn = 9'h1A5; tick(); NextState = 0;
    checks++;
    if (pc_a !== 9'd11 || cs_a !== 2'b01 || prev_a !== 9'h1A5) begin
      errors++;
      $display("FAIL target_mode got pc=%0d cs=%0d prev=%h exp pc=11 cs=1 prev=1a5", pc_a, cs_a, prev_a);
    end
    BranchEn = 1; BranchTarget = 9'h0C8; NextState = 2'b10; tick();
    BranchEn = 0; NextState = 0;
    checks++;
    if (pc_a !== 9'd200 || cs_a !== 2'b00) begin
      errors++;
      $display("FAIL branch got pc=%0d cs=%0d exp pc=200 cs=0", pc_a, cs_a);
    end
  endtask

  task automatic test_ack_priority();
    Ack = 1; tick(); Ack = 0;
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 20; i++) tick();
    Ack = 1; BranchEn = 1; BranchTarget = 9'd77; PrevInstructionIn = 9'h0FF; tick();
    Ack = 0; BranchEn = 0;
    checks++;
    if (done_a !== 1'b1 || pc_a !== 9'd20 || prev_a === 9'h0FF) begin
      errors++;
      $display("FAIL ack_over_branch got done=%0d pc=%0d prev=%h exp done=1 pc=20 prev!=0ff",
               done_a, pc_a, prev_a);
    end
    Start = 1; tick(); Start = 0; tick();
    Start = 1; tick(); Start = 0;
    checks++;
    if (pc_a !== 9'd2 || run_a !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run got pc=%0d run=%0d exp pc=2 run=1", pc_a, run_a);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (pc_b !== 9'd15 || run_b !== 1'b1 || flt_b !== 1'b0) begin
      errors++;
      $display("FAIL at_last_pc got pc=%0d run=%0d flt=%0d exp pc=15 run=1 flt=0", pc_b, run_b, flt_b);
    end
    tick();
    checks++;
    if (done_b !== 1'b1 || flt_b !== 1'b1 || pc_b !== 9'd15 || cnt_b !== 4'd15) begin
      errors++;
      $display("FAIL overrun got done=%0d flt=%0d pc=%0d cnt=%0d exp done=1 flt=1 pc=15 cnt=15",
               done_b, flt_b, pc_b, cnt_b);
    end
    Start = 1; tick(); Start = 0;
    checks++;
    if (run_b !== 1'b1 || done_b !== 1'b0 || flt_b !== 1'b0 || pc_b !== 9'd0) begin
      errors++;
      $display("FAIL overrun_restart got run=%0d done=%0d flt=%0d pc=%0d exp 1 0 0 0",
               run_b, done_b, flt_b, pc_b);
    end
  endtask

  task automatic test_cmp_and_illegal();
    do_reset();
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 4; i++) tick();
    CMPLoadEn = 1; CMPBitsIn = 3'b011; tick(); CMPLoadEn = 0; CMPBitsIn = 3'b100;
    checks++;
    if (pc_a !== 9'd5 || cmp_a !== 3'b011) begin
      errors++;
      $display("FAIL cmp_load got pc=%0d cmp=%b exp pc=5 cmp=011", pc_a, cmp_a);
    end
    tick();
    checks++;
    if (pc_a !== 9'd6 || cmp_a !== 3'b011 || flt_a !== 1'b0) begin
      errors++;
      $display("FAIL cmp_hold got pc=%0d cmp=%b flt=%0d exp pc=6 cmp=011 flt=0", pc_a, cmp_a, flt_a);
    end
    NextState = 2'b11; tick(); NextState = 0;
    checks++;
    if (pc_a !== 9'd7 || cs_a !== 2'b00 || flt_a !== 1'b1 || run_a !== 1'b1) begin
      errors++;
      $display("FAIL illegal_mode got pc=%0d cs=%0d flt=%0d run=%0d exp pc=7 cs=0 flt=1 run=1",
               pc_a, cs_a, flt_a, run_a);
    end
    tick();
    checks++;
    if (flt_a !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky got flt=%0d exp 1", flt_a);
    end
  endtask

  task automatic test_random();
    logic [48:0] got, exp;
    int shown = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      Start             = ($urandom_range(0, 7) == 0);
      Ack               = ($urandom_range(0, 39) == 0);
      BranchEn          = ($urandom_range(0, 9) == 0);
      BranchTarget      = 9'($urandom_range(0, 511));
      NextState         = 2'($urandom_range(0, 3));
      PrevInstructionIn = 9'($urandom_range(0, 511));
      CMPLoadEn         = 1'($urandom_range(0, 1));
      CMPBitsIn         = 3'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < 2; k++) begin
        exp = {9'(m_pc[k]), 2'(m_mode[k]), 9'(m_prev[k]), 3'(m_cmp[k]),
               (m_ph[k] == 1), (m_ph[k] == 2), 1'(m_flt[k]), 16'(m_cnt[k])};
        if (k == 0) got = {pc_a, cs_a, prev_a, cmp_a, run_a, done_a, flt_a, cnt_a};
        else        got = {pc_b, cs_b, prev_b, cmp_b, run_b, done_b, flt_b, 12'd0, cnt_b};
        checks++;
        if (got !== exp) begin
          errors++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random[%0d] dut%0d got %h exp %h", n, k, got, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_and_ack();
    test_branch();
    test_ack_priority();
    test_overrun();
    test_cmp_and_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the architectural sequencing state that the combinational control decoder reads and requests changes to: program counter, decode mode (CurrState), previous-instruction register and compare-flag register. Each cycle it takes the decoder's BranchEn/BranchTarget/NextState/Ack requests and commits them on the clock edge. It also runs the Start/Done program handshake with the test harness. It sits between the instruction ROM address input and the decoder feedback outputs.

Parameters:
PC_W, 9, program counter width; matches the 9-bit branch-target field.
PROG_LEN, 512, number of valid instruction words; legal PC range is 0..PROG_LEN-1.
START_PC, 0, PC loaded on program start.
CNT_W, 16, width of the RUN-cycle counter.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  level; a high level sampled in IDLE or DONE launches the program.
BranchEn  in  1  decoder request: load BranchTarget into the PC.
BranchTarget  in  9  decoder branch destination.
NextState  in  2  decoder-requested decode mode (00 regular, 01 target, 10 immediate, 11 illegal).
PrevInstructionIn  in  9  current instruction word, forwarded by the decoder.
CMPLoadEn  in  1  decoder request to update the compare flags.
CMPBitsIn  in  3  new compare flags {zero, equal, gt}.
Ack  in  1  decoder "program finished" indication.
ProgCtr  out  PC_W  instruction ROM address.
CurrState  out  2  decode mode fed back to the decoder.
PrevInstruction  out  9  previous instruction word fed back to the decoder.
CMPBits  out  3  registered compare flags.
Running  out  1  high in RUN; top level ANDs all decoder write enables with this.
Done  out  1  high in DONE.
Fault  out  1  sticky; set on PC overrun or illegal NextState.
CycleCount  out  CNT_W  number of RUN cycles in the current or last program.

Behaviour:
- Reset (async): FSM=IDLE. ProgCtr=START_PC, CurrState=00, PrevInstruction=0, CMPBits=000, Running=0, Done=0, Fault=0, CycleCount=0. A reset asserted mid-RUN aborts immediately; no partial commit occurs.
- FSM states are IDLE, RUN, DONE. Running and Done are decoded directly from the state register.
- IDLE to RUN when Start=1 at an edge:
  - ProgCtr=START_PC, CurrState=00, PrevInstruction=0.
  - CMPBits=000, Fault=0, CycleCount=0.
- RUN, commit on each edge. Priority is Ack > BranchEn > overrun > sequential.
  - Ack=1: go to DONE. ProgCtr and CurrState hold. No other updates occur that cycle except CMPBits if CMPLoadEn=1.
  - BranchEn=1: ProgCtr=BranchTarget[PC_W-1:0] and CurrState=00, regardless of NextState.
  - Else if ProgCtr==PROG_LEN-1: go to DONE and set Fault=1. ProgCtr holds.
  - Else: ProgCtr=ProgCtr+1 and CurrState=NextState. If NextState=11, load 00 instead and set Fault=1.
  - PrevInstruction=PrevInstructionIn on every non-Ack RUN edge.
  - CMPBits=CMPBitsIn whenever CMPLoadEn=1.
  - CycleCount increments on every RUN edge, including the Ack edge, and saturates at all-ones.
- Start while in RUN is ignored.
- DONE: all outputs hold. Start=1 at an edge performs the same restart as from IDLE; Done falls in the same cycle that Running rises.
- A BranchTarget ≥ PROG_LEN is loaded as given; the overrun check applies only to sequential increment.
- Latency: a request presented in cycle n is visible on the outputs in cycle n+1.

Decomposition:
- Shared package (Definitions) holds:
  - the decode-mode enum: MODE_REG=00, MODE_TARGET=01, MODE_IMM=10, MODE_NOP=11;
  - the fetch FSM enum {F_IDLE, F_RUN, F_DONE};
  - the CMP bit-index constants CMP_ZERO=2, CMP_EQ=1, CMP_GT=0.
- One natural sub-module: sat_counter (CNT_W-bit counter with clear, enable and saturate), used for CycleCount.

Test Plan:
1. Reset mid-RUN at ProgCtr=37: ProgCtr→0, CurrState→00, Running→0, Fault→0 immediately, without waiting for a clock edge.
2. Start pulse, then 5 cycles with no requests: ProgCtr=5, CycleCount=5, Running=1. Ack in cycle 6: Done=1, ProgCtr holds 5, CycleCount=6.
3. NextState=01 at PC=10, then BranchEn=1 with BranchTarget=9'h0C8: ProgCtr sequence 10, 11, 200; CurrState sequence 01, then 00.
4. Ack=1 and BranchEn=1 in the same cycle at PC=20: DONE entered, ProgCtr stays 20.
5. PROG_LEN=16, free-run to PC=15: next edge gives DONE with Fault=1 and ProgCtr=15. Start from DONE restarts with Fault=0 and PC=0.
6. CMPLoadEn=1 with CMPBitsIn=3'b011 at PC=4: CMPBits=011 from PC=5 onward. NextState=11 at PC=6: CurrState=00 and Fault=1.
